// File: rtl/note_arbiter.sv
// note_arbiter
// Chooses the single note sent to the square-wave tone generator from the set
// of keys currently held on the keyboard.
//  - Held keys live in a small stack, oldest in slot 0 and newest on top.
//  - With arp_en low the newest key sounds (last-pressed priority).
//  - With arp_en high the held keys are stepped through in age order.
//  - Whenever one note gives way to a different note, a short burst of
//    silence is inserted so that the new note is heard as a fresh attack.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   ev_valid    key event present
//   ev_ready    event accepted on a clk edge when ev_valid & ev_ready
//               (high whenever rst is low; there is no backpressure)
//   ev_press    1 = key pressed, 0 = key released
//   ev_note     6-bit note code of the event
//   arp_en      1 = arpeggio mode, 0 = last-pressed priority
//   note_out    registered note code to the tone generator, 6'h3F = silence
//   playing     registered, high when note_out is not silence
//   held_count  number of valid stack entries
module note_arbiter #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 100000,
  parameter int ARP_TICKS  = 12500000,
  parameter int NOTE_MAX   = 35
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic                           ev_press,
  input  logic [5:0]                     ev_note,
  input  logic                           arp_en,
  output logic [5:0]                     note_out,
  output logic                           playing,
  output logic [$clog2(DEPTH+1)-1:0]     held_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int AW = $clog2(ARP_TICKS);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [5:0]    Silence  = 6'h3F;
  localparam logic [5:0]    NoteMaxC = 6'(NOTE_MAX);
  localparam logic [AW-1:0] ArpLastC = AW'(ARP_TICKS - 1);
  localparam logic [GW-1:0] GapLastC = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    SILENT,
    SOUND,
    GAP
  } state_t;

  logic [5:0]    stack_q [DEPTH];
  logic [5:0]    stack_d [DEPTH];
  logic [CW-1:0] heldCount_q, heldCount_d;
  logic [AW-1:0] arpCnt_q, arpCnt_d;
  logic [IW-1:0] arpIdx_q, arpIdx_d;
  logic [GW-1:0] gapCnt_q, gapCnt_d;
  state_t        state_q, state_d;
  logic [5:0]    noteOut_q, noteOut_d;
  logic          playing_q;
  logic [5:0]    target;

  assign ev_ready   = ~rst;
  assign note_out   = noteOut_q;
  assign playing    = playing_q;
  assign held_count = heldCount_q;

  // Stack maintenance and arpeggio stepping. Every accepted event is folded
  // into one "remove a slot, then maybe append" operation: a re-press removes
  // the old copy, a press into a full stack removes slot 0, a release of a
  // held key removes it. Slots at or above held_count are always kept at
  // silence so that compaction pulls silence down into the vacated slot.
  // The arpeggio step is evaluated against the post-event count so that a
  // simultaneous event and step both land on the same edge.
  always_comb begin
    int  cntI;
    int  hitIdx;
    int  removeIdx;
    int  idxI;
    logic hit;
    logic removeEn;

    stack_d     = stack_q;
    heldCount_d = heldCount_q;
    arpCnt_d    = arpCnt_q;
    arpIdx_d    = arpIdx_q;
    cntI        = int'(heldCount_q);
    hitIdx      = 0;
    removeIdx   = 0;
    idxI        = 0;
    hit         = 1'b0;
    removeEn    = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && i < cntI && stack_q[i] == ev_note) begin
        hit    = 1'b1;
        hitIdx = i;
      end
    end

    if (ev_valid && ev_ready && ev_note <= NoteMaxC && (ev_press || hit)) begin
      removeEn  = hit || (cntI == DEPTH);
      removeIdx = hit ? hitIdx : 0;
      if (removeEn) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (i >= removeIdx) begin
            stack_d[i] = stack_q[i + 1];
          end
        end
        stack_d[DEPTH-1] = Silence;
        cntI = cntI - 1;
      end
      if (ev_press) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == cntI) begin
            stack_d[i] = ev_note;
          end
        end
        cntI = cntI + 1;
      end
      heldCount_d = CW'(cntI);
    end

    if (!arp_en || cntI < 2) begin
      arpCnt_d = '0;
      arpIdx_d = '0;
    end else begin
      idxI = int'(arpIdx_q);
      if (idxI >= cntI) begin
        idxI = 0;
      end
      if (arpCnt_q == ArpLastC) begin
        arpCnt_d = '0;
        idxI     = idxI + 1;
        if (idxI >= cntI) begin
          idxI = 0;
        end
      end else begin
        arpCnt_d = arpCnt_q + AW'(1);
      end
      arpIdx_d = IW'(idxI);
    end
  end

  // Target note seen by the output FSM, taken from the registered stack.
  always_comb begin
    int selI;
    target = Silence;
    selI   = arp_en ? int'(arpIdx_q) : int'(heldCount_q) - 1;
    if (heldCount_q != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == selI) begin
          target = stack_q[i];
        end
      end
    end
  end

  // Output FSM. A change between two real notes always passes through GAP;
  // going silent, or sounding from silence, happens straight away. The gap
  // runs its full length even if the target moves meanwhile, and the note
  // that finally sounds is whatever the target is on the closing edge.
  always_comb begin
    state_d   = state_q;
    noteOut_d = noteOut_q;
    gapCnt_d  = gapCnt_q;
    case (state_q)
      SILENT: begin
        if (target != Silence) begin
          state_d   = SOUND;
          noteOut_d = target;
        end
      end
      SOUND: begin
        if (target == Silence) begin
          state_d   = SILENT;
          noteOut_d = Silence;
        end else if (target != noteOut_q) begin
          state_d   = GAP;
          noteOut_d = Silence;
          gapCnt_d  = '0;
        end
      end
      GAP: begin
        if (gapCnt_q == GapLastC) begin
          gapCnt_d = '0;
          if (target != Silence) begin
            state_d   = SOUND;
            noteOut_d = target;
          end else begin
            state_d   = SILENT;
            noteOut_d = Silence;
          end
        end else begin
          gapCnt_d = gapCnt_q + GW'(1);
        end
      end
      default: begin
        state_d   = SILENT;
        noteOut_d = Silence;
        gapCnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= Silence;
      end
      heldCount_q <= '0;
      arpCnt_q    <= '0;
      arpIdx_q    <= '0;
      gapCnt_q    <= '0;
      state_q     <= SILENT;
      noteOut_q   <= Silence;
      playing_q   <= 1'b0;
    end else begin
      stack_q     <= stack_d;
      heldCount_q <= heldCount_d;
      arpCnt_q    <= arpCnt_d;
      arpIdx_q    <= arpIdx_d;
      gapCnt_q    <= gapCnt_d;
      state_q     <= state_d;
      noteOut_q   <= noteOut_d;
      playing_q   <= (noteOut_d != Silence);
    end
  end

endmodule

// File: tb/tb_note_arbiter.sv
// tb_note_arbiter
// Directed bench for note_arbiter with DEPTH=4, GAP_CYCLES=4, ARP_TICKS=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_note_arbiter;

  logic       clk;
  logic       rst;
  logic       evValid;
  logic       evReady;
  logic       evPress;
  logic [5:0] evNote;
  logic       arpEn;
  logic [5:0] noteOut;
  logic       playing;
  logic [2:0] heldCount;

  int compareCount  = 0;
  int mismatchCount = 0;

  note_arbiter #(
    .DEPTH(4),
    .GAP_CYCLES(4),
    .ARP_TICKS(8),
    .NOTE_MAX(35)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ev_valid(evValid),
    .ev_ready(evReady),
    .ev_press(evPress),
    .ev_note(evNote),
    .arp_en(arpEn),
    .note_out(noteOut),
    .playing(playing),
    .held_count(heldCount)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed != expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Presents one key event, lets it be accepted on the next edge and
  // returns 1 unit after that edge with ev_valid dropped.
  task automatic applyStimulus(input logic press, input logic [5:0] note);
    evValid = 1'b1;
    evPress = press;
    evNote  = note;
    @(posedge clk);
    #1;
    evValid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    evValid = 1'b0;
    evPress = 1'b0;
    evNote  = 6'd0;
    arpEn   = 1'b0;

    #2;
    checkOutput("por_note", noteOut, 63);
    checkOutput("por_playing", playing, 0);
    checkOutput("por_held", heldCount, 0);
    checkOutput("por_ready", evReady, 0);
    #10 rst = 1'b0;
    waitCycles(1);
    checkOutput("ready_after_reset", evReady, 1);

    // Asynchronous reset while a note sounds
    applyStimulus(1'b1, 6'd9);
    waitCycles(1);
    checkOutput("t1_sounding", noteOut, 9);
    #3 rst = 1'b1;
    #1;
    checkOutput("t1_async_note", noteOut, 63);
    checkOutput("t1_async_playing", playing, 0);
    checkOutput("t1_async_held", heldCount, 0);
    checkOutput("t1_async_ready", evReady, 0);
    #2 rst = 1'b0;
    waitCycles(1);
    checkOutput("t1_after_note", noteOut, 63);

    // Basic priority and gaps
    applyStimulus(1'b1, 6'd9);
    checkOutput("t2_held1", heldCount, 1);
    checkOutput("t2_not_yet", noteOut, 63);
    waitCycles(1);
    checkOutput("t2_note9", noteOut, 9);
    checkOutput("t2_playing9", playing, 1);
    applyStimulus(1'b1, 6'd20);
    checkOutput("t2_hold9", noteOut, 9);
    waitCycles(1);
    checkOutput("t2_gap_start", noteOut, 63);
    checkOutput("t2_gap_playing", playing, 0);
    waitCycles(3);
    checkOutput("t2_gap_end", noteOut, 63);
    waitCycles(1);
    checkOutput("t2_note20", noteOut, 20);
    applyStimulus(1'b0, 6'd20);
    waitCycles(1);
    checkOutput("t2_rel_gap_start", noteOut, 63);
    waitCycles(3);
    checkOutput("t2_rel_gap_end", noteOut, 63);
    waitCycles(1);
    checkOutput("t2_back_to_9", noteOut, 9);
    applyStimulus(1'b0, 6'd9);
    checkOutput("t2_held0", heldCount, 0);
    waitCycles(1);
    checkOutput("t2_silent_nogap", noteOut, 63);
    checkOutput("t2_silent_playing", playing, 0);

    // Overflow drops the oldest key
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 6'(k));
    end
    checkOutput("t3_held_full", heldCount, 4);
    checkOutput("t3_in_gap", noteOut, 63);
    waitCycles(2);
    checkOutput("t3_note5", noteOut, 5);
    applyStimulus(1'b0, 6'd5);
    checkOutput("t3_held3", heldCount, 3);
    waitCycles(1);
    checkOutput("t3_rel_gap", noteOut, 63);
    waitCycles(3);
    checkOutput("t3_rel_gap_end", noteOut, 63);
    waitCycles(1);
    checkOutput("t3_note4", noteOut, 4);
    applyStimulus(1'b0, 6'd1);
    checkOutput("t3_dropped_rel_held", heldCount, 3);
    waitCycles(1);
    checkOutput("t3_dropped_rel_note", noteOut, 4);
    applyStimulus(1'b0, 6'd2);
    applyStimulus(1'b0, 6'd3);
    applyStimulus(1'b0, 6'd4);
    waitCycles(1);
    checkOutput("t3_clear_held", heldCount, 0);
    checkOutput("t3_clear_note", noteOut, 63);

    // Arpeggio: steps of 8 cycles, each change preceded by a 4-cycle gap
    arpEn = 1'b1;
    applyStimulus(1'b1, 6'd2);
    applyStimulus(1'b1, 6'd7);
    applyStimulus(1'b1, 6'd11);
    checkOutput("t4_held3", heldCount, 3);
    checkOutput("t4_first2", noteOut, 2);
    waitCycles(6);
    checkOutput("t4_n6_still2", noteOut, 2);
    waitCycles(1);
    checkOutput("t4_n7_gap", noteOut, 63);
    waitCycles(4);
    checkOutput("t4_n11_note7", noteOut, 7);
    waitCycles(3);
    checkOutput("t4_n14_still7", noteOut, 7);
    waitCycles(1);
    checkOutput("t4_n15_gap", noteOut, 63);
    waitCycles(4);
    checkOutput("t4_n19_note11", noteOut, 11);
    waitCycles(7);
    checkOutput("t4_n26_gap", noteOut, 63);
    waitCycles(1);
    checkOutput("t4_n27_wrap2", noteOut, 2);
    waitCycles(8);
    checkOutput("t4_n35_note7", noteOut, 7);
    waitCycles(4);
    checkOutput("t4_n39_gap", noteOut, 63);
    applyStimulus(1'b0, 6'd11);
    checkOutput("t4_rel11_held", heldCount, 2);
    checkOutput("t4_rel11_gap", noteOut, 63);
    waitCycles(2);
    checkOutput("t4_n42_gap", noteOut, 63);
    waitCycles(1);
    checkOutput("t4_n43_idx0_note2", noteOut, 2);
    arpEn = 1'b0;
    applyStimulus(1'b0, 6'd7);
    applyStimulus(1'b0, 6'd2);
    waitCycles(6);
    checkOutput("t4_clear_held", heldCount, 0);
    checkOutput("t4_clear_note", noteOut, 63);
    checkOutput("t4_clear_playing", playing, 0);

    // Re-press moves a key to the top; out-of-range codes are ignored
    applyStimulus(1'b1, 6'd3);
    applyStimulus(1'b1, 6'd6);
    waitCycles(5);
    checkOutput("t5_note6", noteOut, 6);
    applyStimulus(1'b1, 6'd3);
    checkOutput("t5_repress_held", heldCount, 2);
    waitCycles(1);
    checkOutput("t5_repress_gap", noteOut, 63);
    waitCycles(3);
    checkOutput("t5_repress_gap_end", noteOut, 63);
    waitCycles(1);
    checkOutput("t5_note3", noteOut, 3);
    applyStimulus(1'b1, 6'd40);
    checkOutput("t5_ready40", evReady, 1);
    checkOutput("t5_held_after40", heldCount, 2);
    applyStimulus(1'b1, 6'd63);
    waitCycles(1);
    checkOutput("t5_held_after63", heldCount, 2);
    checkOutput("t5_note_after63", noteOut, 3);

    // Release everything during a gap, then reset during a gap
    applyStimulus(1'b1, 6'd6);
    waitCycles(1);
    checkOutput("t6_gap", noteOut, 63);
    applyStimulus(1'b0, 6'd3);
    applyStimulus(1'b0, 6'd6);
    checkOutput("t6_held0", heldCount, 0);
    checkOutput("t6_in_gap", noteOut, 63);
    waitCycles(3);
    checkOutput("t6_after_gap_note", noteOut, 63);
    checkOutput("t6_after_gap_playing", playing, 0);
    applyStimulus(1'b1, 6'd9);
    waitCycles(1);
    checkOutput("t6_silent_then_9", noteOut, 9);
    applyStimulus(1'b1, 6'd12);
    waitCycles(2);
    checkOutput("t6_gap_before_rst", noteOut, 63);
    #3 rst = 1'b1;
    #1;
    checkOutput("t6_rst_held", heldCount, 0);
    checkOutput("t6_rst_note", noteOut, 63);
    checkOutput("t6_rst_ready", evReady, 0);
    #2 rst = 1'b0;
    waitCycles(6);
    checkOutput("t6_post_rst_note", noteOut, 63);
    checkOutput("t6_post_rst_held", heldCount, 0);
    checkOutput("t6_post_rst_playing", playing, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
